pixel_frame_writer: RTL and testbench

PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

---
 rtl/pixel_frame_writer.sv | 162 ++++++++++++++++
 tb/tb_pixel_frame_writer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_writer.sv
// rtl/pixel_frame_writer.sv - camera pixel capture into a double-buffered frame store via a FWFT write FIFO
module pixel_frame_writer #(
    parameter int FRAME_PIXELS = 307200,
    parameter int ADDR_W       = 19,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clock_pclk,
    input  logic              pin_reset,
    input  logic              vs,
    input  logic [15:0]       i_data,
    input  logic              i_flag,
    output logic [ADDR_W:0]   o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_wr_en,
    input  logic              i_wr_ready,
    output logic              o_disp_bank,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt,
    output logic              o_overflow,
    output logic              o_frame_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 1 + ADDR_W + 16;
    localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] FRAME_C  = ADDR_W'(FRAME_PIXELS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t             state;
    logic               vs_d;
    logic               armed;
    logic               overrun;
    logic               wr_bank;
    logic [ADDR_W-1:0]  pix_idx;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;

    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               accept;
    logic               in_range;
    logic               frame_start;
    logic               frame_end;
    logic [ENTRY_W-1:0] head;

    // armed blocks a false frame start when reset is released in the middle of an active frame
    assign frame_start = vs_d && !vs && armed;
    assign frame_end   = !vs_d && vs;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign pop        = !fifo_empty && i_wr_ready;
    assign accept     = (state == ACTIVE) && i_flag;
    assign in_range   = (pix_idx < FRAME_C);
    assign push       = accept && in_range && (!fifo_full || pop);

    assign head      = fifo_mem[rd_ptr];
    assign o_wr_en   = !fifo_empty;
    assign o_wr_addr = fifo_empty ? '0 : head[ENTRY_W-1:16];
    assign o_wr_data = fifo_empty ? '0 : head[15:0];

    always_ff @(posedge clock_pclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wr_bank, pix_idx, i_data};
        end
    end

    always_ff @(posedge clock_pclk or negedge pin_reset) begin
        if (!pin_reset) begin
            state        <= IDLE;
            vs_d         <= 1'b1;
            armed        <= 1'b0;
            overrun      <= 1'b0;
            wr_bank      <= 1'b0;
            pix_idx      <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            o_disp_bank  <= 1'b1;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= 8'd0;
            o_overflow   <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            vs_d         <= vs;
            o_frame_done <= 1'b0;
            if (vs) begin
                armed <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state       <= ACTIVE;
                        pix_idx     <= '0;
                        overrun     <= 1'b0;
                        o_overflow  <= 1'b0;
                        o_frame_err <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        if (in_range) begin
                            pix_idx <= pix_idx + 1'b1;
                            if (!push) begin
                                o_overflow <= 1'b1;
                            end
                        end else begin
                            overrun     <= 1'b1;
                            o_frame_err <= 1'b1;
                        end
                    end
                    if (frame_end) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // a frame that starts while draining is skipped; IDLE waits for the following one
                    if (frame_start) begin
                        o_frame_err <= 1'b1;
                    end
                    if (fifo_empty) begin
                        // a long frame saturates the index at the full count, so overrun vetoes the swap
                        if (pix_idx == FRAME_C && !overrun) begin
                            wr_bank      <= ~wr_bank;
                            o_disp_bank  <= wr_bank;
                            o_frame_done <= 1'b1;
                            o_frame_cnt  <= o_frame_cnt + 8'd1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb/tb_pixel_frame_writer.sv - frame-level scoreboard bench for pixel_frame_writer
module tb_pixel_frame_writer;

    localparam int FP    = 16;
    localparam int DEPTH = 8;

    logic        clock_pclk;
    logic        pin_reset;
    logic        vs;
    logic [15:0] i_data;
    logic        i_flag;
    logic [19:0] o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_wr_en;
    logic        i_wr_ready;
    logic        o_disp_bank;
    logic        o_frame_done;
    logic [7:0]  o_frame_cnt;
    logic        o_overflow;
    logic        o_frame_err;

    pixel_frame_writer #(.FRAME_PIXELS(FP), .ADDR_W(19), .FIFO_DEPTH(DEPTH)) dut (
        .clock_pclk  (clock_pclk),
        .pin_reset   (pin_reset),
        .vs          (vs),
        .i_data      (i_data),
        .i_flag      (i_flag),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_wr_en     (o_wr_en),
        .i_wr_ready  (i_wr_ready),
        .o_disp_bank (o_disp_bank),
        .o_frame_done(o_frame_done),
        .o_frame_cnt (o_frame_cnt),
        .o_overflow  (o_overflow),
        .o_frame_err (o_frame_err)
    );

    initial clock_pclk = 1'b0;
    always #5 clock_pclk = ~clock_pclk;

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int n;
        int mode;
        bit coinc;
        bit exp_err;
    } vec_t;

    int   checks;
    int   errors;
    wr_t  q[$];
    bit   m_bank;
    bit   m_disp;
    int   m_cnt;
    int   acc;
    int   drops;
    int   done_seen;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // one pixel-clock cycle: drive at the falling edge, score the write that the next rising edge performs
    task automatic step(input bit v, input bit f, input logic [15:0] d, input bit rdy, input bit act);
        bit  canpop;
        wr_t e;
        vs = v;
        i_flag = f;
        i_data = d;
        i_wr_ready = rdy;
        chk("wr_en", {31'd0, o_wr_en}, {31'd0, q.size() != 0});
        canpop = (q.size() != 0) && rdy;
        if (canpop) begin
            chk("wr_addr", {12'd0, o_wr_addr}, {12'd0, q[0].addr});
            chk("wr_data", {16'd0, o_wr_data}, {16'd0, q[0].data});
        end
        if (o_frame_done === 1'b1) done_seen++;
        if (f && act) begin
            if (acc < FP) begin
                if (q.size() < DEPTH || canpop) begin
                    e.addr = m_bank ? (20'h80000 + 20'(acc)) : 20'(acc);
                    e.data = d;
                    q.push_back(e);
                end else begin
                    drops++;
                end
            end
            acc++;
        end
        if (canpop) void'(q.pop_front());
        @(negedge clock_pclk);
    endtask

    task automatic start_frame();
        acc = 0;
        drops = 0;
        done_seen = 0;
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic finish_frame(input bit exp_err);
        int k;
        bit swap;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
            k++;
        end
        chk("drain_bound", q.size(), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        swap = (acc == FP);
        if (swap) begin
            m_disp = m_bank;
            m_bank = ~m_bank;
            m_cnt  = (m_cnt + 1) % 256;
        end
        chk("frame_done_pulses", done_seen, swap ? 1 : 0);
        chk("disp_bank", {31'd0, o_disp_bank}, {31'd0, m_disp});
        chk("frame_cnt", {24'd0, o_frame_cnt}, m_cnt);
        chk("overflow", {31'd0, o_overflow}, {31'd0, drops != 0});
        chk("frame_err", {31'd0, o_frame_err}, {31'd0, exp_err});
    endtask

    task automatic run_frame(input int n, input int mode, input bit coinc, input bit exp_err);
        bit          rdy;
        bit          v;
        logic [15:0] d;
        int          gaps;
        start_frame();
        for (int i = 0; i < n; i++) begin
            if (mode == 1) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, 16'h0, 1'($urandom), 1'b1);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom);
                default: rdy = (i >= 10);
            endcase
            d = (mode == 0) ? 16'(i) : 16'($urandom);
            v = coinc && (i == n - 1);
            step(v, 1'b1, d, rdy, 1'b1);
        end
        if (!coinc) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        finish_frame(exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        m_bank = 1'b0;
        m_disp = 1'b1;
        m_cnt  = 0;
        vecs[0] = '{n: 16, mode: 0, coinc: 1'b0, exp_err: 1'b0};
        vecs[1] = '{n: 16, mode: 0, coinc: 1'b0, exp_err: 1'b0};
        vecs[2] = '{n: 16, mode: 2, coinc: 1'b0, exp_err: 1'b0};
        vecs[3] = '{n: 12, mode: 0, coinc: 1'b0, exp_err: 1'b1};
        vecs[4] = '{n: 20, mode: 0, coinc: 1'b0, exp_err: 1'b1};
        vecs[5] = '{n: 16, mode: 0, coinc: 1'b1, exp_err: 1'b0};
        vecs[6] = '{n: 16, mode: 1, coinc: 1'b0, exp_err: 1'b0};
        vecs[7] = '{n: 16, mode: 1, coinc: 1'b1, exp_err: 1'b0};
        vecs[8] = '{n: 16, mode: 1, coinc: 1'b0, exp_err: 1'b0};

        pin_reset  = 1'b1;
        vs         = 1'b1;
        i_data     = 16'h0;
        i_flag     = 1'b0;
        i_wr_ready = 1'b1;
        #2 pin_reset = 1'b0;
        #1;
        chk("rst_wr_en", {31'd0, o_wr_en}, 0);
        chk("rst_disp_bank", {31'd0, o_disp_bank}, 1);
        chk("rst_frame_cnt", {24'd0, o_frame_cnt}, 0);
        chk("rst_frame_err", {31'd0, o_frame_err}, 0);
        @(negedge clock_pclk);
        pin_reset = 1'b1;
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);

        for (int r = 0; r < 9; r++) begin
            run_frame(vecs[r].n, vecs[r].mode, vecs[r].coinc, vecs[r].exp_err);
        end

        // short frame still draining on a stalled memory when the next frame starts
        start_frame();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16'($urandom), 1'b1, 1'b0);
        finish_frame(1'b1);
        run_frame(16, 0, 1'b0, 1'b0);

        // reset in the middle of a frame with pixels still queued
        start_frame();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0, 1'b1);
        i_flag = 1'b0;
        pin_reset = 1'b0;
        #1;
        chk("mid_rst_wr_en", {31'd0, o_wr_en}, 0);
        chk("mid_rst_wr_addr", {12'd0, o_wr_addr}, 0);
        chk("mid_rst_wr_data", {16'd0, o_wr_data}, 0);
        chk("mid_rst_disp_bank", {31'd0, o_disp_bank}, 1);
        chk("mid_rst_frame_done", {31'd0, o_frame_done}, 0);
        chk("mid_rst_frame_cnt", {24'd0, o_frame_cnt}, 0);
        chk("mid_rst_overflow", {31'd0, o_overflow}, 0);
        chk("mid_rst_frame_err", {31'd0, o_frame_err}, 0);
        q.delete();
        m_bank = 1'b0;
        m_disp = 1'b1;
        m_cnt  = 0;
        @(negedge clock_pclk);
        pin_reset = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'($urandom), 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        run_frame(16, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
